// File: rtl/sigmoid_pkg.sv
// Shared types for the sigmoid sharing arbiter: tag pipeline entries,
// response FIFO entries and a small index helper.
package sigmoid_pkg;

    localparam int FP32_W   = 32;
    localparam int TAG_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        logic [FP32_W-1:0]   y;
    } rsp_entry_t;

    // Next requester index after idx, wrapping at n.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sigmoid_share_arbiter_if.sv
// Requester and response handshake bundle of the sigmoid sharing arbiter.
interface sigmoid_share_arbiter_if
    import sigmoid_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [FP32_W*N_REQ-1:0] req_x;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [FP32_W-1:0]       rsp_y;

    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y
    );

endinterface

// File: rtl/sigmoid_rsp_fifo.sv
// Registered (non fall-through) synchronous FIFO holding tagged sigmoid results.
// A pop on a full FIFO frees the slot used by a same-edge push.
module sigmoid_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 36,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sigmoid_share_arbiter.sv
// Round-robin sharing of one fixed-latency sigmoid datapath between N_REQ
// requesters; results are tagged and returned through a credit-guarded FIFO.
module sigmoid_share_arbiter
    import sigmoid_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int SIG_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sigmoid_share_arbiter_if.slave  bus,
    output logic [FP32_W-1:0]       sig_x,
    input  logic [FP32_W-1:0]       sig_y
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             issue_ok;
    logic             handshake;
    int               inflight_cnt;
    tag_t             tags [SIG_LATENCY];

    logic             push;
    logic             pop;
    rsp_entry_t       push_entry;
    rsp_entry_t       head;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             unused_id_bits;

    // Credits cover both in-flight tags and queued entries, so every capture
    // finds a free slot; a pop in the same cycle is deliberately not counted.
    always_comb begin
        inflight_cnt = 0;
        for (int k = 0; k < SIG_LATENCY; k++) begin
            inflight_cnt = inflight_cnt + (tags[k].valid ? 1 : 0);
        end
        issue_ok = (inflight_cnt + int'(fifo_cnt)) < FIFO_DEPTH;
    end

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin : arb_search
        int          idx;
        logic [ID_W-1:0] cand;
        idx    = 0;
        cand   = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx  = (int'(ptr) + k) % N_REQ;
            cand = ID_W'(idx);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && found && issue_ok) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    assign handshake = |(bus.req_valid & bus.req_ready);

    // Stage 0 of the tag pipeline is loaded together with sig_x, so the last
    // stage is valid exactly while sig_y carries the matching result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            sig_x <= '0;
            for (int k = 0; k < SIG_LATENCY; k++) begin
                tags[k] <= '0;
            end
        end else begin
            if (handshake) begin
                ptr     <= ID_W'(next_idx(int'(winner), N_REQ));
                sig_x   <= bus.req_x[int'(winner)*FP32_W +: FP32_W];
                tags[0] <= '{valid: 1'b1, id: TAG_ID_W'(winner)};
            end else begin
                tags[0] <= '0;
            end
            for (int k = 1; k < SIG_LATENCY; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    assign push       = tags[SIG_LATENCY-1].valid;
    assign push_entry = '{id: tags[SIG_LATENCY-1].id, y: sig_y};
    assign pop        = bus.rsp_valid && bus.rsp_ready;

    sigmoid_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rsp_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_id    = head.id[ID_W-1:0];
    assign bus.rsp_y     = head.y;
    assign unused_id_bits = ^head.id;

    // A capture into a full FIFO without a pop would lose a result.
    overflow_chk : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Scoreboard bench for sigmoid_share_arbiter with a sign-flipping sigmoid stub,
// plus a standalone probe of the response FIFO's full push/pop behaviour.
module tb_sigmoid_share_arbiter;
    import sigmoid_pkg::*;

    localparam int N_REQ       = 4;
    localparam int SIG_LATENCY = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int ID_W        = 2;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     y;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] sig_x;
    logic [31:0] sig_y;

    exp_t exp_q [$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   exp_ptr = 0;

    logic       f_push = 1'b0;
    logic       f_pop  = 1'b0;
    logic [7:0] f_wdata = '0;
    logic [7:0] f_rdata;
    logic [2:0] f_count;
    logic       f_full;
    logic       f_empty;

    always #5 clk = ~clk;

    sigmoid_share_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    sigmoid_share_arbiter #(
        .N_REQ       (N_REQ),
        .SIG_LATENCY (SIG_LATENCY),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ID_W        (ID_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sig_x (sig_x),
        .sig_y (sig_y)
    );

    sigmoid_rsp_fifo #(.DEPTH(4), .WIDTH(8)) u_fifo_probe (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (f_push),
        .wdata (f_wdata),
        .pop   (f_pop),
        .rdata (f_rdata),
        .count (f_count),
        .full  (f_full),
        .empty (f_empty)
    );

    // Sigmoid stub: together with the DUT's sig_x register this gives
    // SIG_LATENCY register stages, y = x with the sign bit flipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_y <= '0;
        else        sig_y <= sig_x ^ 32'h8000_0000;
    end

    // Scoreboard: push on every request handshake, pop and compare on every response.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_q.push_back('{id: ID_W'(i), y: bus.req_x[i*32 +: 32] ^ 32'h8000_0000});
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("[TB] FAIL rsp_unexpected: got id=%0d y=%h, required no response", bus.rsp_id, bus.rsp_y);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rsp_id !== e.id || bus.rsp_y !== e.y) begin
                        n_bad++;
                        $display("[TB] FAIL rsp_data: got id=%0d y=%h, required id=%0d y=%h", bus.rsp_id, bus.rsp_y, e.id, e.y);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_x();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_x[i*32 +: 32] = $urandom();
        end
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 60) begin
            @(negedge clk);
            #1;
            c++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        randomize_x();
        #2 rst_n = 1'b0;
        #2;
        n_cmp += 5;
        if (bus.req_ready !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_req_ready: got %b, required 0000", bus.req_ready); end
        if (sig_x !== 32'h0)           begin n_bad++; $display("[TB] FAIL reset_sig_x: got %h, required 0", sig_x); end
        if (bus.rsp_valid !== 1'b0)    begin n_bad++; $display("[TB] FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
        if (bus.rsp_id !== 2'd0)       begin n_bad++; $display("[TB] FAIL reset_rsp_id: got %0d, required 0", bus.rsp_id); end
        if (bus.rsp_y !== 32'h0)       begin n_bad++; $display("[TB] FAIL reset_rsp_y: got %h, required 0", bus.rsp_y); end
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        exp_ptr = 0;
        tick();
    endtask

    task automatic test_single();
        int c;
        int lat;
        bus.req_x[31:0] = 32'h40E0_0000;
        bus.req_valid   = 4'b0001;
        bus.rsp_ready   = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.req_ready[0] !== 1'b1 && c < 20);
        n_cmp++;
        if (bus.req_ready[0] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL single_grant: got req_ready=%b, required 0001 within 20 cycles", bus.req_ready);
        end
        exp_ptr = 1;
        lat = 1;
        tick();
        bus.req_valid = '0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp += 3;
        if (lat != SIG_LATENCY + 2) begin n_bad++; $display("[TB] FAIL single_latency: got %0d cycles, required %0d", lat, SIG_LATENCY + 2); end
        if (bus.rsp_id !== 2'd0)        begin n_bad++; $display("[TB] FAIL single_rsp_id: got %0d, required 0", bus.rsp_id); end
        if (bus.rsp_y !== 32'hC0E0_0000) begin n_bad++; $display("[TB] FAIL single_rsp_y: got %h, required c0e00000", bus.rsp_y); end
        wait_drain("single");
    endtask

    task automatic test_contention();
        logic [N_REQ-1:0] want;
        randomize_x();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            want = N_REQ'(1 << exp_ptr);
            n_cmp++;
            if (bus.req_ready !== want) begin
                n_bad++;
                $display("[TB] FAIL contention_grant[%0d]: got %b, required %b", cyc, bus.req_ready, want);
            end
            exp_ptr = next_idx(exp_ptr, N_REQ);
            tick();
            randomize_x();
        end
        bus.req_valid = '0;
        wait_drain("contention");
    endtask

    task automatic test_backpressure();
        int hs;
        logic [N_REQ-1:0] want;
        hs = 0;
        randomize_x();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) hs++;
            tick();
        end
        exp_ptr = (exp_ptr + FIFO_DEPTH) % N_REQ;
        @(negedge clk);
        n_cmp += 3;
        if (hs != FIFO_DEPTH)         begin n_bad++; $display("[TB] FAIL bp_handshakes: got %0d, required %0d", hs, FIFO_DEPTH); end
        if (bus.req_ready !== '0)     begin n_bad++; $display("[TB] FAIL bp_stalled: got req_ready=%b, required 0000", bus.req_ready); end
        if (bus.rsp_valid !== 1'b1)   begin n_bad++; $display("[TB] FAIL bp_rsp_valid: got %b, required 1", bus.rsp_valid); end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== '0) begin n_bad++; $display("[TB] FAIL bp_pop_not_credited: got %b, required 0000", bus.req_ready); end
        tick();
        @(negedge clk);
        want = N_REQ'(1 << exp_ptr);
        n_cmp++;
        if (bus.req_ready !== want) begin n_bad++; $display("[TB] FAIL bp_resume: got %b, required %b", bus.req_ready, want); end
        exp_ptr = next_idx(exp_ptr, N_REQ);
        tick();
        bus.req_valid = '0;
        wait_drain("backpressure");
    endtask

    task automatic test_sparse();
        int c;
        int exp_seq [3];
        logic [N_REQ-1:0] want;
        exp_seq = '{3, 1, 3};
        randomize_x();
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.req_ready[1] !== 1'b1 && c < 20);
        tick();
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            want = N_REQ'(1 << exp_seq[k]);
            n_cmp++;
            if (bus.req_ready !== want) begin
                n_bad++;
                $display("[TB] FAIL sparse_grant[%0d]: got %b, required %b", k, bus.req_ready, want);
            end
            tick();
        end
        bus.req_valid = '0;
        exp_ptr = 0;
        wait_drain("sparse");
    endtask

    task automatic test_reset_midflight();
        int hs;
        int c;
        int stray;
        hs = 0;
        c = 0;
        stray = 0;
        randomize_x();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        while (hs < 3 && c < 20) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) hs++;
            c++;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_cmp += 5;
        if (bus.req_ready !== '0)   begin n_bad++; $display("[TB] FAIL midrst_req_ready: got %b, required 0000", bus.req_ready); end
        if (sig_x !== 32'h0)        begin n_bad++; $display("[TB] FAIL midrst_sig_x: got %h, required 0", sig_x); end
        if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_rsp_valid: got %b, required 0", bus.rsp_valid); end
        if (bus.rsp_id !== 2'd0)    begin n_bad++; $display("[TB] FAIL midrst_rsp_id: got %0d, required 0", bus.rsp_id); end
        if (bus.rsp_y !== 32'h0)    begin n_bad++; $display("[TB] FAIL midrst_rsp_y: got %h, required 0", bus.rsp_y); end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) stray++;
        end
        n_cmp++;
        if (stray != 0) begin n_bad++; $display("[TB] FAIL midrst_stray: got %0d cycles with rsp_valid, required 0", stray); end
        tick();
        bus.req_valid = '1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin n_bad++; $display("[TB] FAIL midrst_ptr: got %b, required 0001", bus.req_ready); end
        exp_ptr = 1;
        tick();
        bus.req_valid = '0;
        wait_drain("midrst");
    endtask

    task automatic test_collision();
        int hs;
        int c;
        logic [N_REQ-1:0] want;
        hs = 0;
        c = 0;
        randomize_x();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        while (hs < FIFO_DEPTH && c < 20) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) hs++;
            c++;
            tick();
        end
        exp_ptr = (exp_ptr + FIFO_DEPTH) % N_REQ;
        tick();
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        want = N_REQ'(1 << exp_ptr);
        n_cmp++;
        if (bus.req_ready !== want) begin n_bad++; $display("[TB] FAIL coll_regrant: got %b, required %b", bus.req_ready, want); end
        exp_ptr = next_idx(exp_ptr, N_REQ);
        tick();
        bus.req_valid = '0;
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL coll_after: got rsp_valid=%b, required 1", bus.rsp_valid); end
        tick();
        bus.rsp_ready = 1'b1;
        wait_drain("collision");
    endtask

    task automatic test_fifo_full_collision();
        logic [7:0] want;
        for (int i = 0; i < 4; i++) begin
            f_push  = 1'b1;
            f_wdata = 8'(8'h10 + i);
            tick();
        end
        f_push = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (f_full !== 1'b1 || f_count !== 3'd4) begin n_bad++; $display("[TB] FAIL fifo_full: got full=%b count=%0d, required 1/4", f_full, f_count); end
        if (f_rdata !== 8'h10) begin n_bad++; $display("[TB] FAIL fifo_head: got %h, required 10", f_rdata); end
        tick();
        f_push  = 1'b1;
        f_pop   = 1'b1;
        f_wdata = 8'h14;
        tick();
        f_push = 1'b0;
        f_pop  = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (f_count !== 3'd4) begin n_bad++; $display("[TB] FAIL fifo_coll_count: got %0d, required 4", f_count); end
        if (f_rdata !== 8'h11) begin n_bad++; $display("[TB] FAIL fifo_coll_head: got %h, required 11", f_rdata); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            want = 8'(8'h11 + i);
            n_cmp++;
            if (f_rdata !== want) begin n_bad++; $display("[TB] FAIL fifo_order[%0d]: got %h, required %h", i, f_rdata, want); end
            tick();
            f_pop = 1'b1;
            tick();
            f_pop = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (f_empty !== 1'b1) begin n_bad++; $display("[TB] FAIL fifo_empty: got %b, required 1", f_empty); end
        tick();
        f_push  = 1'b1;
        f_pop   = 1'b1;
        f_wdata = 8'h5A;
        tick();
        f_push = 1'b0;
        f_pop  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (f_count !== 3'd1 || f_rdata !== 8'h5A) begin n_bad++; $display("[TB] FAIL fifo_empty_pushpop: got count=%0d head=%h, required 1/5a", f_count, f_rdata); end
        tick();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_sparse();
        test_reset_midflight();
        test_collision();
        test_fifo_full_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
